// File: rtl/reflet_bus_arbiter_pkg.sv
// Shared encodings for the Reflet two-master bus arbiter.
package reflet_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOCK0 = 2'b01,
        LOCK1 = 2'b10
    } arb_state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/reflet_arbiter_rdata.sv
// Per-master read-return path: flags a read one cycle after its transfer and
// gates the OR-bus read data so the master sees 0 when no data is for it.
module reflet_arbiter_rdata #(
    parameter int wordsize = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                xfer_read,
    input  logic [wordsize-1:0] data_in,
    output logic                rvalid,
    output logic [wordsize-1:0] data_out
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) rvalid <= 1'b0;
        else        rvalid <= xfer_read;
    end

    assign data_out = rvalid ? data_in : '0;

endmodule

// File: rtl/reflet_bus_arbiter.sv
// Round-robin arbiter sharing the Reflet bus between CPU (m0) and a second master (m1).
// Bus locking with a max_lock fairness limit is compiled in with REFLET_ARBITER_LOCK_EN.
module reflet_bus_arbiter
    import reflet_bus_arbiter_pkg::*;
#(
    parameter int wordsize = 16,
    parameter int max_lock = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_req,
    input  logic                m1_req,
    input  logic                m0_lock,
    input  logic                m1_lock,
    input  logic [wordsize-1:0] m0_addr,
    input  logic [wordsize-1:0] m1_addr,
    input  logic                m0_write_en,
    input  logic                m1_write_en,
    input  logic [wordsize-1:0] m0_data_in,
    input  logic [wordsize-1:0] m1_data_in,
    output logic                m0_gnt,
    output logic                m1_gnt,
    output logic                m0_rvalid,
    output logic                m1_rvalid,
    output logic [wordsize-1:0] m0_data_out,
    output logic [wordsize-1:0] m1_data_out,
    output logic                enable,
    output logic [wordsize-1:0] addr,
    output logic                write_en,
    output logic [wordsize-1:0] data_out,
    input  logic [wordsize-1:0] data_in
);

    localparam logic [7:0] LOCK_MAX = 8'(max_lock);

    arb_state_t state;
    logic       prio;
    logic       gnt0, gnt1;
    logic       force_release;

`ifdef REFLET_ARBITER_LOCK_EN
    arb_state_t state_next;
    logic [7:0] lock_cnt, cnt_next;
    logic       other_req;

    always_comb begin
        state_next    = state;
        cnt_next      = lock_cnt;
        force_release = 1'b0;
        other_req     = (state == LOCK0) ? m1_req : m0_req;
        case (state)
            IDLE: begin
                if (gnt0 && m0_lock)      state_next = LOCK0;
                else if (gnt1 && m1_lock) state_next = LOCK1;
            end
            LOCK0, LOCK1: begin
                // The starved master's wait is bounded to LOCK_MAX locked cycles.
                if (other_req) begin
                    cnt_next = lock_cnt + 8'd1;
                    if (cnt_next >= LOCK_MAX) force_release = 1'b1;
                end
                if (force_release)                              state_next = IDLE;
                else if (state == LOCK0 && gnt0 && !m0_lock)    state_next = IDLE;
                else if (state == LOCK1 && gnt1 && !m1_lock)    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (state_next != state) cnt_next = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            lock_cnt <= cnt_next;
        end
    end
`else
    logic unused_lock;
    assign unused_lock   = m0_lock | m1_lock | (|LOCK_MAX);
    assign state         = IDLE;
    assign force_release = 1'b0;
`endif

    // Grants are suppressed while reset is held so the bus floats to 0 at once.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (reset) begin
            case (state)
                LOCK0:   gnt0 = m0_req;
                LOCK1:   gnt1 = m1_req;
                default: begin
                    gnt0 = m0_req && (!m1_req || prio == M0);
                    gnt1 = m1_req && (!m0_req || prio == M1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)             prio <= M0;
        else if (force_release) prio <= (state == LOCK0) ? M1 : M0;
        else if (gnt0)          prio <= M1;
        else if (gnt1)          prio <= M0;
    end

    assign m0_gnt   = gnt0;
    assign m1_gnt   = gnt1;
    assign enable   = gnt0 | gnt1;
    assign addr     = gnt0 ? m0_addr     : (gnt1 ? m1_addr     : '0);
    assign write_en = gnt0 ? m0_write_en : (gnt1 ? m1_write_en : 1'b0);
    assign data_out = gnt0 ? m0_data_in  : (gnt1 ? m1_data_in  : '0);

    reflet_arbiter_rdata #(.wordsize(wordsize)) u_rdata0 (
        .clk       (clk),
        .reset     (reset),
        .xfer_read (gnt0 & ~m0_write_en),
        .data_in   (data_in),
        .rvalid    (m0_rvalid),
        .data_out  (m0_data_out)
    );

    reflet_arbiter_rdata #(.wordsize(wordsize)) u_rdata1 (
        .clk       (clk),
        .reset     (reset),
        .xfer_read (gnt1 & ~m1_write_en),
        .data_in   (data_in),
        .rvalid    (m1_rvalid),
        .data_out  (m1_data_out)
    );

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Scoreboard bench for reflet_bus_arbiter: a driver predicts each cycle's outputs from
// an ownership-level model; a negedge monitor pops and compares.
module tb_reflet_bus_arbiter;
    localparam int WS = 16;
    localparam int ML = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          m0_req = 0, m1_req = 0, m0_lock = 0, m1_lock = 0;
    logic [WS-1:0] m0_addr = 0, m1_addr = 0, m0_data_in = 0, m1_data_in = 0;
    logic          m0_write_en = 0, m1_write_en = 0;
    logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, enable, write_en;
    logic [WS-1:0] m0_data_out, m1_data_out, addr, data_out;
    logic [WS-1:0] data_in = 0;

    reflet_bus_arbiter #(.wordsize(WS), .max_lock(ML)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_write_en(m0_write_en), .m1_write_en(m1_write_en),
        .m0_data_in(m0_data_in), .m1_data_in(m1_data_in),
        .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
        .m0_data_out(m0_data_out), .m1_data_out(m1_data_out),
        .enable(enable), .addr(addr), .write_en(write_en), .data_out(data_out),
        .data_in(data_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          g0, g1, en, we, rv0, rv1;
        logic [WS-1:0] addr, dout, d0, d1;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passed = 0;

    // Model: owner = master holding a lock (-1 none), held = locked cycles the other waited.
    int       owner = -1;
    int       held = 0;
    int       mprio = 0;
    bit [1:0] mrv = 2'b00;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("grant", {61'b0, m0_gnt, m1_gnt, enable}, {61'b0, e.g0, e.g1, e.en});
            chk("bus", {31'b0, addr, write_en, data_out}, {31'b0, e.addr, e.we, e.dout});
            chk("rdata", {30'b0, m0_rvalid, m1_rvalid, m0_data_out, m1_data_out},
                {30'b0, e.rv0, e.rv1, e.d0, e.d1});
        end
    end

    task automatic step(input bit rst,
                        input bit r0, input bit l0, input bit w0, input logic [WS-1:0] a0, input logic [WS-1:0] d0,
                        input bit r1, input bit l1, input bit w1, input logic [WS-1:0] a1, input logic [WS-1:0] d1,
                        input logic [WS-1:0] din);
        exp_t     e;
        int       win;
        bit [1:0] rq, lk;
        reset = rst;
        m0_req = r0; m0_lock = l0; m0_write_en = w0; m0_addr = a0; m0_data_in = d0;
        m1_req = r1; m1_lock = l1; m1_write_en = w1; m1_addr = a1; m1_data_in = d1;
        data_in = din;
        rq = {r1, r0};
        lk = {l1, l0};
        if (!rst) begin
            owner = -1; held = 0; mprio = 0; mrv = 2'b00;
        end
        win = -1;
        if (rst) begin
            if (owner < 0) begin
                if (r0 && r1) win = mprio;
                else if (r0)  win = 0;
                else if (r1)  win = 1;
            end else if (rq[owner]) win = owner;
        end
        e.g0   = (win == 0);
        e.g1   = (win == 1);
        e.en   = (win >= 0);
        e.addr = (win == 0) ? a0 : (win == 1) ? a1 : '0;
        e.we   = (win == 0) ? w0 : (win == 1) ? w1 : 1'b0;
        e.dout = (win == 0) ? d0 : (win == 1) ? d1 : '0;
        e.rv0  = mrv[0];
        e.rv1  = mrv[1];
        e.d0   = mrv[0] ? din : '0;
        e.d1   = mrv[1] ? din : '0;
        sbq.push_back(e);
        @(posedge clk);
        if (rst) begin
            mrv[0] = (win == 0) && !w0;
            mrv[1] = (win == 1) && !w1;
            if (win >= 0) mprio = 1 - win;
`ifdef REFLET_ARBITER_LOCK_EN
            if (owner < 0) begin
                if (win >= 0 && lk[win]) begin owner = win; held = 0; end
            end else begin
                int other;
                other = 1 - owner;
                if (rq[other]) held++;
                if (held >= ML) begin
                    mprio = other; owner = -1; held = 0;
                end else if (win == owner && !lk[owner]) begin
                    owner = -1; held = 0;
                end
            end
`else
            if (lk != 2'b00) held = 0;
`endif
        end
        #1;
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Reset state, including requests present while reset is held.
        step(0, 0,0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      16'h0);
        step(0, 1,0,1,16'h1111,16'h2222, 1,0,1,16'h3333,16'h4444, 16'hFFFF);
        // m0 alone writes 0x8004.
        step(1, 1,0,1,16'h8004,16'h1234, 0,0,0,16'h0,16'h0,      16'h0);
        step(1, 0,0,0,16'h0,16'h0,      1,0,1,16'h0040,16'h5555, 16'h0);
        // Both requesting continuously: strict alternation.
        for (int i = 0; i < 6; i++)
            step(1, 1,0,1,16'(16'h0100 + i),16'hA000, 1,0,1,16'(16'h0200 + i),16'hB000, 16'h0);
        // m1 read at 0x8010, slave answers BEEF next cycle.
        step(1, 0,0,0,16'h0,16'h0,      1,0,0,16'h8010,16'h0,    16'h0);
        step(1, 0,0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      16'hBEEF);
        // m0 burst of 4 with lock while m1 keeps requesting (forced release at ML=3).
        step(1, 1,1,1,16'h9000,16'h1,   1,0,1,16'h9100,16'h2,   16'h0);
        step(1, 1,1,1,16'h9001,16'h1,   1,0,1,16'h9100,16'h2,   16'h0);
        step(1, 1,1,1,16'h9002,16'h1,   1,0,1,16'h9100,16'h2,   16'h0);
        step(1, 1,0,1,16'h9003,16'h1,   1,0,1,16'h9100,16'h2,   16'h0);
        step(1, 1,0,1,16'h9004,16'h1,   1,0,1,16'h9101,16'h2,   16'h0);
        step(1, 0,0,0,16'h0,16'h0,      1,0,1,16'h9102,16'h2,   16'h0);
        // m1 locks with a read, then reset arrives while the read data is pending.
        step(1, 0,0,0,16'h0,16'h0,      1,1,0,16'h7000,16'h0,   16'h0);
        step(0, 1,0,0,16'h0,16'h0,      1,1,0,16'h7001,16'h0,   16'hCAFE);
        step(0, 1,0,0,16'h0,16'h0,      1,1,0,16'h7001,16'h0,   16'hCAFE);
        step(1, 1,0,1,16'h6000,16'h6,   1,0,1,16'h6100,16'h7,   16'h0);
        // m0 asserting lock while both request.
        for (int i = 0; i < 6; i++)
            step(1, 1,1,1,16'h5000,16'h5,   1,0,1,16'h5100,16'h6,   16'h0);
        step(1, 0,0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      16'h0);
        // Random traffic.
        for (int i = 0; i < 400; i++)
            step(1, 1'($urandom % 2), ($urandom % 4) == 0, 1'($urandom % 2), 16'($urandom), 16'($urandom),
                    1'($urandom % 2), ($urandom % 4) == 0, 1'($urandom % 2), 16'($urandom), 16'($urandom),
                    16'($urandom));
        step(1, 0,0,0,16'h0,16'h0,      0,0,0,16'h0,16'h0,      16'h0);
        @(negedge clk);
        #1;
        chk("queue_drained", 64'(sbq.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/reflet_bus_arbiter.md
# reflet_bus_arbiter

Two-master arbiter that shares the Reflet system bus between the CPU (master 0) and a secondary requester such as a DMA or debug port (master 1). It sits between the masters and the OR-combined slave bus (UART, ROM, RAM). Per-cycle arbitration is round-robin. A master may lock the bus for a burst. Read data is routed back to whichever master issued the read.

## Interface
Parameters:
- wordsize, 16: data and address width.
- max_lock, 16: maximum consecutive cycles a locked master may hold the bus while the other master is requesting (range 1..255).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- m0_req, m1_req  in  1  transaction valid.
- m0_lock, m1_lock  in  1  keep ownership after this transfer.
- m0_addr, m1_addr  in  wordsize  transaction address.
- m0_write_en, m1_write_en  in  1  1 = write, 0 = read.
- m0_data_in, m1_data_in  in  wordsize  write data.
- m0_gnt, m1_gnt  out  1  transfer accepted this cycle (combinational).
- m0_rvalid, m1_rvalid  out  1  read data valid (registered).
- m0_data_out, m1_data_out  out  wordsize  read data; 0 when the matching rvalid is low.
- enable  out  1  bus cycle active.
- addr  out  wordsize  bus address.
- write_en  out  1  bus write strobe.
- data_out  out  wordsize  bus write data.
- data_in  in  wordsize  OR-combined slave read data, valid one cycle after the read cycle.

## Operation
- Transfer rule: a transfer for master k happens in a cycle where mk_req and mk_gnt are both 1 at the rising edge. Never more than one gnt is high.
- State machine states: IDLE, LOCK0, LOCK1. Also holds a priority pointer prio (0 or 1).
- IDLE, single requester: that master is granted.
- IDLE, both requesting: master prio is granted.
- After any transfer by master k, prio is set to the other master (1-k).
- IDLE -> LOCKk: on a transfer by k with mk_lock=1.
- LOCKk behaviour:
  - mk_gnt = mk_req; the other gnt is 0.
  - If mk_req is low, the bus is idle and the other master waits.
- LOCKk -> IDLE: on a transfer by k with mk_lock=0.
- Lock counter:
  - Counts cycles spent in LOCKk while the other master is requesting.
  - On reaching max_lock, the next edge forces IDLE with prio = 1-k. A transfer on that same edge still completes.
  - Cleared whenever the state changes.
- Bus drive:
  - enable = OR of the transfer conditions.
  - addr, write_en and data_out are muxed from the granted master.
  - All four are 0 when no master is granted (OR-bus convention).
- Read return:
  - mk_rvalid is registered; it is 1 in the cycle after a transfer by k with write_en=0.
  - mk_data_out = mk_rvalid ? data_in : 0.

## Timing
- Grant latency is 0 cycles: gnt is combinational from the req inputs plus registered state.
- Read latency: data arrives 1 cycle after the transfer, concurrent with rvalid.
- Back-to-back transfers are allowed every cycle.
- With both masters requesting continuously and no lock, grants strictly alternate 0,1,0,1,...
- Reset values:
  - State IDLE, prio 0, lock counter 0.
  - m0_rvalid = m1_rvalid = 0.
  - Both data_out ports are 0 and no master is granted until a req arrives.
- Reset mid-burst: the lock and any pending rvalid are dropped asynchronously and bus outputs fall to 0 in the same cycle. A read in flight is lost, and the master must reissue it.
- Simultaneous first requests after reset: master 0 wins.

## Configuration
- REFLET_ARBITER_LOCK_EN defined: LOCK0/LOCK1 states and the max_lock counter are compiled in.
- Undefined: m0_lock and m1_lock are ignored, the FSM never leaves IDLE, and no counter logic is present. Ports are unchanged.

## Structure
- Shared package holds:
  - the state encoding constants (IDLE=2'b00, LOCK0=2'b01, LOCK1=2'b10);
  - the master index constants.
- Natural sub-module: reflet_arbiter_rdata, which holds the per-master rvalid register and the gated read-data return, instantiated twice.

## Test plan
- Reset released, m0_req=1 alone, addr 16'h8004, write_en=1 -> m0_gnt=1 same cycle; enable=1, addr=16'h8004 on the bus; m1_gnt=0.
- Both masters request continuously for 6 cycles, no lock -> gnt sequence 0,1,0,1,0,1.
- m1 read at 16'h8010 while the slave returns 16'hBEEF next cycle -> m1_rvalid=1 and m1_data_out=16'hBEEF one cycle later; m0_data_out=0.
- Macro defined, m0 locks for 4 transfers while m1 requests -> m1 is granted only after the m0 transfer with m0_lock=0. With max_lock=3 the lock is instead forced off after 3 cycles and m1 is granted.
- Reset pulled low during LOCK1 with a read pending -> all gnt, rvalid and bus outputs are 0 immediately; after release, simultaneous requests grant m0.
- Macro undefined, m0_lock=1 with both masters requesting -> grants still alternate.
